nlfsr_search_ctrl: RTL and testbench
====================================

Name: nlfsr_search_ctrl

Overview:
- Search controller that wraps one NLFSR shift-register stage.
- Upstream role: drives the stage's clear, enable and feedback bit. Feedback is computed combinationally from the stage's state and the current candidate tap set.
- Downstream role: consumes the stage's found/failure flags and sweeps every candidate tap set.
- Full-period candidates are emitted on a valid/ready hit stream for capture by the host logic.

Parameters:
- SIZE, 16, width of the NLFSR state being driven.
- IDXW, $clog2(SIZE), width of one tap index.
- CW, 3*IDXW, candidate width, packed {a,b,c} with a in the MSBs.
- TIMEOUT, 2**SIZE+1, maximum RUN cycles per candidate before it is abandoned.

Ports:
- clk  in  1  clock, rising edge.
- res  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse; begins a sweep from candidate 0.
- busy  out  1  high from the cycle after an accepted start until DONE is entered.
- done  out  1  high in DONE; holds until the next accepted start.
- nlfsr_state  in  SIZE  current state of the NLFSR stage.
- nlfsr_found  in  1  full-period flag from the stage.
- nlfsr_failure  in  1  short-period flag from the stage.
- nlfsr_res  out  1  synchronous active-high clear to the stage.
- nlfsr_ena  out  1  step enable to the stage.
- nlfsr_feedback  out  1  feedback bit to the stage.
- hit_valid  out  1  hit stream valid.
- hit_ready  in  1  hit stream ready.
- hit_taps  out  CW  candidate that achieved full period.

Behaviour:
- Reset (res=0, async): state IDLE, cand=0, cyc_cnt=0. busy, done, nlfsr_res, nlfsr_ena and hit_valid are all 0; hit_taps=0.
- Feedback is combinational, zero latency:
  - nlfsr_feedback = s[SIZE-1] ^ s[a] ^ (s[b] & s[c]), where s=nlfsr_state.
  - Indices >= SIZE wrap modulo SIZE.
  - Degenerate sets (a=SIZE-1, b=c) are evaluated as-is, never skipped.
- IDLE: start=1 -> CLEAR with cand=0, busy=1.
- CLEAR (1 cycle): nlfsr_res=1, nlfsr_ena=0, cyc_cnt<=0 -> RUN.
- RUN: nlfsr_ena=1, cyc_cnt++. Flags are registered in the stage; they are sampled here, one cycle after the causing state. Priority order:
  1. nlfsr_found=1 -> REPORT.
  2. nlfsr_failure=1 -> NEXT.
  3. cyc_cnt==TIMEOUT -> NEXT (period longer than expected, or the all-ones state is never revisited).
- Leaving RUN drops nlfsr_ena the same cycle. At most one step past the flag is tolerated.
- found and failure in the same cycle: found wins.
- REPORT: hit_valid=1 and hit_taps=cand. hit_taps is stable while hit_valid && !hit_ready. Transfer on valid&&ready -> NEXT. Backpressure stalls the sweep indefinitely with nlfsr_ena=0.
- NEXT (1 cycle):
  - cand == all-ones -> DONE (busy=0, done=1).
  - Otherwise cand++ -> CLEAR.
- DONE: start=1 -> CLEAR with cand=0, done=0, busy=1.
- start is ignored in every state except IDLE and DONE.
- cyc_cnt width is SIZE+1 and saturates at TIMEOUT.
- Mid-sweep async reset aborts to IDLE. A pending hit is dropped.

Optional Feature:
- Macro: SEARCH_STATS_EN.
- When defined:
  - Adds outputs hit_cnt (CW+1 bits), fail_cnt (CW+1 bits) and tmo_cnt (CW+1 bits).
  - These count REPORT entries, failure exits and timeout exits.
  - All three clear on res and on accepted start, and hold after DONE.
- When undefined: these ports and counters do not exist; all other behaviour is identical.

Decomposition:
- Shared package nlfsr_pkg holds:
  - the state enum (IDLE, CLEAR, RUN, REPORT, NEXT, DONE);
  - a function computing the candidate width from SIZE;
  - the tap-field extraction helpers.
- One natural sub-module, nlfsr_fb_func. It is purely combinational: cand + state -> feedback bit. It is reused by the bench golden model.

Test Plan:
- Stubbed stage, SIZE=4 (CW=6), pulse start, bench asserts nlfsr_found on RUN cycle 5 of cand 0 -> hit_valid=1, hit_taps=6'h00; after hit_ready, next nlfsr_res pulse is for cand 1.
- Stub never flags, SIZE=4 -> exactly 17 RUN cycles per candidate. After 64 candidates done=1 and busy=0. Zero hits; tmo_cnt=64 with SEARCH_STATS_EN.
- Stub asserts found and failure together on cand 6'h15 -> hit_taps=6'h15 is reported and fail_cnt is unchanged.
- hit_ready held 0 for 50 cycles during REPORT -> hit_valid and hit_taps stable, nlfsr_ena=0 throughout; sweep resumes on ready.
- Real NLFSR connected, SIZE=4, full sweep -> hit_taps sequence equals the golden-model list from nlfsr_fb_func brute force, in ascending order.
- res deasserted-to-0 mid-RUN on cand 9 -> all outputs 0 immediately. start after release restarts at cand 0; a start pulse during RUN is ignored.

Source files
------------

// File: rtl/nlfsr_pkg.sv
// Shared types and helpers for the NLFSR tap-set search controller.
// A candidate packs three tap indices {a,b,c}, with a in the most significant field.
package nlfsr_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    RUN,
    REPORT,
    NEXT,
    DONE
  } state_e;

  function automatic int unsigned idx_width(input int unsigned size);
    return (size < 2) ? 1 : $clog2(size);
  endfunction

  function automatic int unsigned cand_width(input int unsigned size);
    return 3 * idx_width(size);
  endfunction

  // pos selects the field counted from the LSB end: 2 = a, 1 = b, 0 = c.
  function automatic int unsigned tap_field(input logic [31:0] cand,
                                            input int unsigned idxw,
                                            input int unsigned pos);
    return (cand >> (pos * idxw)) & ((32'd1 << idxw) - 32'd1);
  endfunction

  function automatic int unsigned tap_a(input logic [31:0] cand, input int unsigned idxw);
    return tap_field(cand, idxw, 2);
  endfunction

  function automatic int unsigned tap_b(input logic [31:0] cand, input int unsigned idxw);
    return tap_field(cand, idxw, 1);
  endfunction

  function automatic int unsigned tap_c(input logic [31:0] cand, input int unsigned idxw);
    return tap_field(cand, idxw, 0);
  endfunction

endpackage

// File: rtl/nlfsr_fb_func.sv
// Combinational NLFSR feedback: s[SIZE-1] ^ s[a] ^ (s[b] & s[c]) for candidate {a,b,c}.
// Tap indices wrap modulo SIZE; degenerate tap sets are evaluated as written.
module nlfsr_fb_func
  import nlfsr_pkg::*;
#(
  parameter  int unsigned SIZE = 16,
  localparam int unsigned IDXW = idx_width(SIZE),
  localparam int unsigned CW   = 3 * IDXW
) (
  input  logic [CW-1:0]   cand_i,
  input  logic [SIZE-1:0] state_i,
  output logic            feedback_o
);

  logic [31:0]     cand_ext;
  logic [IDXW-1:0] idx_a;
  logic [IDXW-1:0] idx_b;
  logic [IDXW-1:0] idx_c;

  assign cand_ext = 32'(cand_i);
  assign idx_a    = IDXW'(tap_a(cand_ext, IDXW) % SIZE);
  assign idx_b    = IDXW'(tap_b(cand_ext, IDXW) % SIZE);
  assign idx_c    = IDXW'(tap_c(cand_ext, IDXW) % SIZE);

  assign feedback_o = state_i[SIZE-1] ^ state_i[idx_a] ^ (state_i[idx_b] & state_i[idx_c]);

endmodule

// File: rtl/nlfsr_search_ctrl.sv
// Sweeps every NLFSR tap candidate through one external shift stage and streams full-period hits.
// Optional hit/failure/timeout counters are built when SEARCH_STATS_EN is defined.
module nlfsr_search_ctrl
  import nlfsr_pkg::*;
#(
  parameter  int unsigned SIZE = 16,
  localparam int unsigned CW   = cand_width(SIZE)
) (
  input  logic            clk,
  input  logic            res,
  input  logic            start,
  output logic            busy,
  output logic            done,
  input  logic [SIZE-1:0] nlfsr_state,
  input  logic            nlfsr_found,
  input  logic            nlfsr_failure,
  output logic            nlfsr_res,
  output logic            nlfsr_ena,
  output logic            nlfsr_feedback,
`ifdef SEARCH_STATS_EN
  output logic [CW:0]     hit_cnt,
  output logic [CW:0]     fail_cnt,
  output logic [CW:0]     tmo_cnt,
`endif
  output logic            hit_valid,
  input  logic            hit_ready,
  output logic [CW-1:0]   hit_taps
);

  localparam int unsigned     CNTW    = SIZE + 1;
  // One cycle beyond the longest legal period lets a registered found flag still win.
  localparam logic [CNTW-1:0] TIMEOUT = CNTW'((64'd1 << SIZE) + 64'd1);

  state_e          state_q, state_d;
  logic [CW-1:0]   cand_q, cand_d;
  logic [CNTW-1:0] cyc_q, cyc_d;
  logic [CNTW-1:0] cyc_inc;
  logic            start_acc;

  assign cyc_inc   = (cyc_q == TIMEOUT) ? cyc_q : cyc_q + CNTW'(1);
  assign start_acc = start && ((state_q == IDLE) || (state_q == DONE));

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      state_q <= IDLE;
      cand_q  <= '0;
      cyc_q   <= '0;
    end else begin
      state_q <= state_d;
      cand_q  <= cand_d;
      cyc_q   <= cyc_d;
    end
  end

  // NOTE: every next-state value gets a default first so no path infers a latch.
  always_comb begin
    state_d = state_q;
    cand_d  = cand_q;
    cyc_d   = cyc_q;
    case (state_q)
      IDLE, DONE: begin
        if (start_acc) begin
          state_d = CLEAR;
          cand_d  = '0;
        end
      end
      CLEAR: begin
        cyc_d   = '0;
        state_d = RUN;
      end
      RUN: begin
        cyc_d = cyc_inc;
        if (nlfsr_found)            state_d = REPORT;
        else if (nlfsr_failure)     state_d = NEXT;
        else if (cyc_inc == TIMEOUT) state_d = NEXT;
      end
      REPORT: begin
        if (hit_ready) state_d = NEXT;
      end
      NEXT: begin
        if (cand_q == '1) begin
          state_d = DONE;
        end else begin
          cand_d  = cand_q + CW'(1);
          state_d = CLEAR;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy      = (state_q == CLEAR) || (state_q == RUN) ||
                     (state_q == REPORT) || (state_q == NEXT);
  assign done      = (state_q == DONE);
  assign nlfsr_res = (state_q == CLEAR);
  assign nlfsr_ena = (state_q == RUN);
  assign hit_valid = (state_q == REPORT);
  assign hit_taps  = hit_valid ? cand_q : '0;

  nlfsr_fb_func #(.SIZE(SIZE)) u_fb (
    .cand_i    (cand_q),
    .state_i   (nlfsr_state),
    .feedback_o(nlfsr_feedback)
  );

`ifdef SEARCH_STATS_EN
  logic          in_run;
  logic          hit_evt, fail_evt, tmo_evt;
  logic [CW:0]   hit_cnt_q, fail_cnt_q, tmo_cnt_q;

  // Mirrors the RUN exit priority: found, then failure, then timeout.
  assign in_run   = (state_q == RUN);
  assign hit_evt  = in_run && nlfsr_found;
  assign fail_evt = in_run && !nlfsr_found && nlfsr_failure;
  assign tmo_evt  = in_run && !nlfsr_found && !nlfsr_failure && (cyc_inc == TIMEOUT);

  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      hit_cnt_q  <= '0;
      fail_cnt_q <= '0;
      tmo_cnt_q  <= '0;
    end else if (start_acc) begin
      hit_cnt_q  <= '0;
      fail_cnt_q <= '0;
      tmo_cnt_q  <= '0;
    end else begin
      if (hit_evt)  hit_cnt_q  <= hit_cnt_q + (CW+1)'(1);
      if (fail_evt) fail_cnt_q <= fail_cnt_q + (CW+1)'(1);
      if (tmo_evt)  tmo_cnt_q  <= tmo_cnt_q + (CW+1)'(1);
    end
  end

  assign hit_cnt  = hit_cnt_q;
  assign fail_cnt = fail_cnt_q;
  assign tmo_cnt  = tmo_cnt_q;
`endif

endmodule

// File: tb/tb_nlfsr_search_ctrl.sv
// Directed bench for nlfsr_search_ctrl at SIZE=4: stubbed stage sequences plus a behavioural stage sweep.
// Counter checks are included when SEARCH_STATS_EN is defined.
module tb_nlfsr_search_ctrl;

  localparam int SIZE = 4;
  localparam int CW   = 6;

  logic            clk = 1'b0;
  logic            res;
  logic            start;
  logic            busy, done;
  logic [SIZE-1:0] nlfsr_state;
  logic            nlfsr_found, nlfsr_failure;
  logic            nlfsr_res, nlfsr_ena, nlfsr_feedback;
  logic            hit_valid, hit_ready;
  logic [CW-1:0]   hit_taps;
`ifdef SEARCH_STATS_EN
  logic [CW:0]     hit_cnt, fail_cnt, tmo_cnt;
`endif

  // Stub drive versus behavioural stage selection.
  logic            use_real;
  logic [SIZE-1:0] stub_state;
  logic            stub_found, stub_fail;

  logic [3:0] stg_s     = 4'hF;
  logic [7:0] stg_steps = 8'd0;
  logic       stg_found = 1'b0;
  logic       stg_fail  = 1'b0;

  assign nlfsr_state   = use_real ? stg_s     : stub_state;
  assign nlfsr_found   = use_real ? stg_found : stub_found;
  assign nlfsr_failure = use_real ? stg_fail  : stub_fail;

  // Stage: clears to all-ones, flags one cycle after it sits at all-ones again.
  always @(posedge clk) begin
    if (nlfsr_res) begin
      stg_s     <= 4'hF;
      stg_steps <= 8'd0;
      stg_found <= 1'b0;
      stg_fail  <= 1'b0;
    end else begin
      stg_found <= (stg_steps != 8'd0) && (stg_s == 4'hF) && (stg_steps == 8'd15);
      stg_fail  <= (stg_steps != 8'd0) && (stg_s == 4'hF) && (stg_steps != 8'd15);
      if (nlfsr_ena) begin
        stg_s     <= {stg_s[2:0], nlfsr_feedback};
        stg_steps <= stg_steps + 8'd1;
      end
    end
  end

  always #5 clk = ~clk;

  nlfsr_search_ctrl #(.SIZE(SIZE)) dut (
    .clk           (clk),
    .res           (res),
    .start         (start),
    .busy          (busy),
    .done          (done),
    .nlfsr_state   (nlfsr_state),
    .nlfsr_found   (nlfsr_found),
    .nlfsr_failure (nlfsr_failure),
    .nlfsr_res     (nlfsr_res),
    .nlfsr_ena     (nlfsr_ena),
    .nlfsr_feedback(nlfsr_feedback),
`ifdef SEARCH_STATS_EN
    .hit_cnt       (hit_cnt),
    .fail_cnt      (fail_cnt),
    .tmo_cnt       (tmo_cnt),
`endif
    .hit_valid     (hit_valid),
    .hit_ready     (hit_ready),
    .hit_taps      (hit_taps)
  );

  logic [CW-1:0]   ref_cand;
  logic [SIZE-1:0] ref_state;
  logic            ref_fb;

  nlfsr_fb_func #(.SIZE(SIZE)) u_fb_ref (
    .cand_i    (ref_cand),
    .state_i   (ref_state),
    .feedback_o(ref_fb)
  );

  typedef struct {
    logic [CW-1:0]   cand;
    logic [SIZE-1:0] state;
    logic            fb;
  } fb_vec_t;

  fb_vec_t fb_tab[10];
  int      n_vec = 0;
  int      n_err = 0;
  int      golden[$];
  int      got[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

`ifdef SEARCH_STATS_EN
  task automatic check_stats(input string name, input int h, input int f, input int t);
    check({name, "_hit_cnt"},  32'(hit_cnt),  32'(h));
    check({name, "_fail_cnt"}, 32'(fail_cnt), 32'(f));
    check({name, "_tmo_cnt"},  32'(tmo_cnt),  32'(t));
  endtask
`endif

  function automatic logic tb_fb(input logic [5:0] c, input logic [3:0] s);
    logic [1:0] a, b, d;
    a = c[5:4];
    b = c[3:2];
    d = c[1:0];
    return s[3] ^ s[a] ^ (s[b] & s[d]);
  endfunction

  task automatic tick();
    @(negedge clk);
  endtask

  // Called in CLEAR; leaves the bench at the next CLEAR (or DONE).
  task automatic fail_cand();
    tick();
    stub_fail = 1'b1;
    tick();
    stub_fail = 1'b0;
    tick();
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit ok;
    bit stable;
    int n_res, n_ena, n_hit, first_len;
    bit first;

    fb_tab[0] = '{6'h00, 4'b1000, 1'b1};
    fb_tab[1] = '{6'h00, 4'b1001, 1'b1};
    fb_tab[2] = '{6'h00, 4'b0001, 1'b0};
    fb_tab[3] = '{6'h1B, 4'b0110, 1'b1};
    fb_tab[4] = '{6'h1B, 4'b1010, 1'b0};
    fb_tab[5] = '{6'h31, 4'b1011, 1'b1};
    fb_tab[6] = '{6'h31, 4'b0001, 1'b0};
    fb_tab[7] = '{6'h25, 4'b0110, 1'b0};
    fb_tab[8] = '{6'h25, 4'b0100, 1'b1};
    fb_tab[9] = '{6'h09, 4'b0001, 1'b1};

    res = 1'b0; start = 1'b0; hit_ready = 1'b0; use_real = 1'b0;
    stub_state = 4'b0001; stub_found = 1'b0; stub_fail = 1'b0;
    ref_cand = '0; ref_state = '0;

    // Reset state.
    repeat (3) tick();
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_nlfsr_res", nlfsr_res, 0);
    check("rst_ena", nlfsr_ena, 0);
    check("rst_hit_valid", hit_valid, 0);
    check("rst_hit_taps", hit_taps, 0);
`ifdef SEARCH_STATS_EN
    check_stats("rst", 0, 0, 0);
`endif
    res = 1'b1;
    tick();

    // Feedback function table, then through the DUT with cand 0.
    foreach (fb_tab[i]) begin
      ref_cand  = fb_tab[i].cand;
      ref_state = fb_tab[i].state;
      #1;
      check($sformatf("fb_tab%0d", i), ref_fb, fb_tab[i].fb);
    end
    stub_state = 4'b1000; #1;
    check("idle_fb_1000", nlfsr_feedback, 1);
    stub_state = 4'b0001; #1;
    check("idle_fb_0001", nlfsr_feedback, 0);
    tick();

    // Found on RUN cycle 5 of cand 0, then 50 cycles of backpressure.
    pulse_start();
    check("t1_clear_busy", busy, 1);
    check("t1_clear_res", nlfsr_res, 1);
    check("t1_clear_ena", nlfsr_ena, 0);
    check("t1_clear_fb_cand0", nlfsr_feedback, 0);
    tick();
    check("t1_run1_ena", nlfsr_ena, 1);
    repeat (4) tick();
    stub_found = 1'b1;
    tick();
    stub_found = 1'b0;
    check("t1_hit_valid", hit_valid, 1);
    check("t1_hit_taps", hit_taps, 6'h00);
    check("t1_report_ena", nlfsr_ena, 0);
    stable = 1'b1;
    repeat (50) begin
      tick();
      if (!(hit_valid === 1'b1 && hit_taps === 6'h00 && nlfsr_ena === 1'b0 && busy === 1'b1))
        stable = 1'b0;
    end
    check("t4_backpressure_stable", stable, 1);
    hit_ready = 1'b1;
    tick();
    hit_ready = 1'b0;
    check("t1_next_valid", hit_valid, 0);
    tick();
    check("t1_cand1_res", nlfsr_res, 1);
    check("t1_cand1_fb", nlfsr_feedback, 1);

    // Fail cands 1..0x14, then found+failure together on 0x15.
    for (int c = 1; c <= 8'h14; c++) fail_cand();
    tick();
    stub_found = 1'b1;
    stub_fail  = 1'b1;
    tick();
    stub_found = 1'b0;
    stub_fail  = 1'b0;
    check("t3_hit_valid", hit_valid, 1);
    check("t3_hit_taps", hit_taps, 6'h15);
`ifdef SEARCH_STATS_EN
    check_stats("t3", 2, 20, 0);
`endif
    hit_ready = 1'b1;
    tick();
    hit_ready = 1'b0;
    tick();
    for (int c = 8'h16; c <= 8'h3F; c++) fail_cand();
    check("t3_done", done, 1);
    check("t3_busy", busy, 0);
    repeat (3) tick();
    check("t3_done_hold", done, 1);
`ifdef SEARCH_STATS_EN
    check_stats("t3_end", 2, 62, 0);
`endif

    // Restart from DONE with a stub that never flags.
    pulse_start();
    check("t2_done_clr", done, 0);
    check("t2_busy", busy, 1);
`ifdef SEARCH_STATS_EN
    check_stats("t2_start", 0, 0, 0);
`endif
    n_res = 1; n_ena = 0; n_hit = 0; first_len = 0; first = 1'b1; ok = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      tick();
      if (done) begin ok = 1'b1; break; end
      if (nlfsr_res) begin n_res++; first = 1'b0; end
      if (nlfsr_ena) begin n_ena++; if (first) first_len++; end
      if (hit_valid) n_hit++;
    end
    check("t2_done_reached", ok, 1);
    check("t2_first_run_len", first_len, 17);
    check("t2_cands", n_res, 64);
    check("t2_run_cycles", n_ena, 64 * 17);
    check("t2_hits", n_hit, 0);
    check("t2_busy_end", busy, 0);
`ifdef SEARCH_STATS_EN
    check_stats("t2_end", 0, 0, 64);
`endif

    // Behavioural stage, full sweep against brute-force golden list.
    for (int c = 0; c < 64; c++) begin
      logic [3:0] s;
      s = 4'hF;
      for (int k = 1; k <= 16; k++) begin
        s = {s[2:0], tb_fb(6'(c), s)};
        if (s == 4'hF) begin
          if (k == 15) golden.push_back(c);
          break;
        end
      end
    end
    use_real  = 1'b1;
    hit_ready = 1'b1;
    pulse_start();
    ok = 1'b0;
    for (int i = 0; i < 6000; i++) begin
      if (done) begin ok = 1'b1; break; end
      if (hit_valid) got.push_back(int'(hit_taps));
      tick();
    end
    hit_ready = 1'b0;
    check("t5_done_reached", ok, 1);
    check("t5_hit_count", got.size(), golden.size());
    for (int i = 0; i < golden.size(); i++)
      check($sformatf("t5_hit%0d", i), (i < got.size()) ? 32'(got[i]) : 32'hFFFF_FFFF,
            32'(golden[i]));
`ifdef SEARCH_STATS_EN
    check("t5_hit_cnt", 32'(hit_cnt), 32'(golden.size()));
`endif

    // Start ignored during RUN, then async reset mid-RUN on cand 9.
    use_real   = 1'b0;
    stub_state = 4'b0001;
    pulse_start();
    for (int c = 0; c < 9; c++) fail_cand();
    tick();
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    check("t6_start_ign_res", nlfsr_res, 0);
    check("t6_start_ign_ena", nlfsr_ena, 1);
    check("t6_start_ign_cand9", nlfsr_feedback, 1);
    tick();
    #2 res = 1'b0;
    #1;
    check("t6_arst_busy", busy, 0);
    check("t6_arst_done", done, 0);
    check("t6_arst_nres", nlfsr_res, 0);
    check("t6_arst_ena", nlfsr_ena, 0);
    check("t6_arst_valid", hit_valid, 0);
    check("t6_arst_taps", hit_taps, 0);
    check("t6_arst_fb", nlfsr_feedback, 0);
`ifdef SEARCH_STATS_EN
    check_stats("t6_arst", 0, 0, 0);
`endif
    tick();
    res = 1'b1;
    tick();
    check("t6_idle_busy", busy, 0);
    pulse_start();
    check("t6_restart_res", nlfsr_res, 1);
    check("t6_restart_cand0", nlfsr_feedback, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
